// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks.
//   RSA_NBITS    : operand / modulus width of the full-size datapath.
//   RSA_CNT_W    : bit-counter width for a full-size Montgomery multiply.
//   mont_state_t : Montgomery multiplier control states.
//   cnt_width()  : counter width for an arbitrary operand width (>= 1 bit).
package rsa_pkg;

  localparam int RSA_NBITS = 4096;
  localparam int RSA_CNT_W = $clog2(RSA_NBITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } mont_state_t;

  function automatic int cnt_width(input int nbits);
    return (nbits > 1) ? $clog2(nbits) : 1;
  endfunction

endpackage

// File: rtl/mont_mul_if.sv
// Start/done request bundle between the exponentiation controller (master)
// and the Montgomery multiplier (slave).
//   start  : master -> slave, request a multiply
//   a, b   : master -> slave, operands (each below n)
//   n      : master -> slave, odd modulus
//   busy   : slave -> master, multiply in progress
//   done   : slave -> master, one-cycle completion pulse
//   err    : slave -> master, latched modulus was even
//   result : slave -> master, Montgomery product
interface mont_mul_if
  import rsa_pkg::*;
#(
  parameter int NBITS = RSA_NBITS
) ();

  logic             start;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic [NBITS-1:0] n;
  logic             busy;
  logic             done;
  logic             err;
  logic [NBITS-1:0] result;

  modport master (
    output start, a, b, n,
    input  busy, done, err, result
  );

  modport slave (
    input  start, a, b, n,
    output busy, done, err, result
  );

endinterface

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration, purely combinational:
//   s_next = (s + a_bit*b + q*n) >> 1, with q chosen to make the sum even.
// Kept as its own module so the two wide adders can later be retimed into
// carry-save form without touching the controller.
//   s      : in,  NBITS+2 bits, current accumulator
//   b      : in,  NBITS bits, multiplier
//   n      : in,  NBITS bits, modulus
//   a_bit  : in,  current multiplicand bit
//   s_next : out, NBITS+2 bits, updated accumulator
module mont_step
  import rsa_pkg::*;
#(
  parameter int NBITS = RSA_NBITS
) (
  input  logic [NBITS+1:0] s,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] n,
  input  logic             a_bit,
  output logic [NBITS+1:0] s_next
);

  // One spare bit above S so that even out-of-range operands cannot wrap.
  logic [NBITS+2:0] t_add;
  logic [NBITS+2:0] t_red;
  logic             unused_t_lsb;

  always_comb begin
    t_add  = {1'b0, s} + {3'b000, (a_bit ? b : {NBITS{1'b0}})};
    // n is odd, so adding it to an odd partial sum makes it divisible by 2.
    t_red  = t_add[0] ? (t_add + {3'b000, n}) : t_add;
    s_next = t_red[NBITS+2:1];
  end

  assign unused_t_lsb = t_red[0];

endmodule

// File: rtl/mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*R^-1 mod n, R = 2^NBITS.
// Latency is NBITS+2 cycles from the accepted start to the done pulse,
// independent of the data.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mont_mul_if slave (start/a/b/n in; busy/done/err/result out)
// Build option: define MONT_FINAL_SUB_EN to fully reduce the result into
// [0, n). Without it the result lies in [0, 2n) and n < 2^(NBITS-1) is needed.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched on acceptance
// ITER  | one multiplicand bit per cycle, NBITS cycles
// FINAL | optional conditional subtract, result register loaded
// DONE  | last busy cycle; done/err registered for the following cycle
module mont_mul
  import rsa_pkg::*;
#(
  parameter int NBITS = RSA_NBITS
) (
  input  logic     clk,
  input  logic     rst_n,
  mont_mul_if.slave bus
);

  localparam int CNT_W = cnt_width(NBITS);
  localparam int SW    = NBITS + 2;

  mont_state_t state, state_nx;

  logic [NBITS-1:0] a_q;
  logic [NBITS-1:0] b_q;
  logic [NBITS-1:0] n_q;
  logic [SW-1:0]    s_q;
  logic [SW-1:0]    s_step;
  logic [CNT_W-1:0] cnt_q;
  logic [NBITS-1:0] result_q;
  logic [NBITS-1:0] result_fin;
  logic [NBITS-1:0] result_red;
  logic             done_q;
  logic             err_q;
  logic             last_iter;

  assign last_iter = (cnt_q == CNT_W'(NBITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = ITER;
      ITER:    if (last_iter) state_nx = FINAL;
      FINAL:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  mont_step #(
    .NBITS (NBITS)
  ) u_step (
    .s      (s_q),
    .b      (b_q),
    .n      (n_q),
    .a_bit  (a_q[cnt_q]),
    .s_next (s_step)
  );

`ifdef MONT_FINAL_SUB_EN
  // S < 2n, so a single subtract lands in [0, n); the low NBITS bits of the
  // difference are exact because S - n < n.
  logic [NBITS-1:0] s_minus_n;

  assign s_minus_n  = s_q[NBITS-1:0] - n_q;
  assign result_red = (s_q >= {2'b00, n_q}) ? s_minus_n : s_q[NBITS-1:0];
`else
  // With n < 2^(NBITS-1), S < 2n fits in NBITS bits; the top two are zero.
  logic unused_s_hi;

  assign result_red  = s_q[NBITS-1:0];
  assign unused_s_hi = ^s_q[SW-1:NBITS];
`endif

  // An even modulus has no inverse of 2; the datapath still runs its full
  // latency but the product is meaningless, so it is forced to zero.
  assign result_fin = n_q[0] ? result_red : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // Registered from DONE so the pulse lands in the first IDLE cycle.
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            n_q   <= bus.n;
            s_q   <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
          end
        end
        ITER: begin
          s_q   <= s_step;
          cnt_q <= cnt_q + 1'b1;
        end
        FINAL: begin
          result_q <= result_fin;
        end
        DONE: begin
          err_q <= ~n_q[0];
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mont_mul.sv
// Directed bench for mont_mul at NBITS=8 with hand-computed Montgomery products
// (n=13, R=256, R^-1 mod 13 = 3).
module tb_mont_mul;

  localparam int NB = 8;

  logic clk;
  logic rst_n;

  mont_mul_if #(.NBITS(NB)) bus ();

  mont_mul #(.NBITS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Call at a negedge. Returns at the negedge where done is seen (lat = index of
  // that cycle counted from the cycle after the accepting edge, -1 on timeout).
  task automatic run_mul(input logic [NB-1:0] ta, input logic [NB-1:0] tb_v,
                         input logic [NB-1:0] tn, output int lat,
                         output int busy_n, output logic err0);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.n     = tn;
    @(posedge clk);
    lat    = -1;
    busy_n = 0;
    err0   = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) begin
        bus.start = 1'b0;
        err0      = bus.err;
      end
      if (bus.done) begin
        lat = j;
        break;
      end
      if (bus.busy) busy_n++;
    end
  endtask

  int   lat;
  int   bsy;
  logic e0;
  int   dones;
  int   first_done;
  logic [NB-1:0] res_snap;

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.n     = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_result", bus.result, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 5*7*R^-1 mod 13 = 105 mod 13 = 1
    run_mul(8'd5, 8'd7, 8'd13, lat, bsy, e0);
    chk("t1_latency", lat, 10);
    chk("t1_busy_cycles", bsy, 10);
    chk("t1_busy_at_done", bus.busy, 0);
    chk("t1_result", bus.result, 1);
    chk("t1_err", bus.err, 0);
    @(negedge clk);
    chk("t1_done_width", bus.done, 0);

    // R^2 mod 13 = 3 times 1 -> R mod 13 = 9
    run_mul(8'd3, 8'd1, 8'd13, lat, bsy, e0);
    chk("t2_latency", lat, 10);
    chk("t2_result", bus.result, 9);

    // Issued in the done cycle of the previous multiply (back-to-back).
    // 144*3 mod 13 = 3
    run_mul(8'd12, 8'd12, 8'd13, lat, bsy, e0);
    chk("t3_latency", lat, 10);
`ifdef MONT_FINAL_SUB_EN
    chk("t3_result", bus.result, 3);
`else
    chk("t3_result_in_set", ((bus.result == 8'd3) || (bus.result == 8'd16)) ? 1 : 0, 1);
`endif
    @(negedge clk);

    // Even modulus
    run_mul(8'd5, 8'd7, 8'd12, lat, bsy, e0);
    chk("t4_latency", lat, 10);
    chk("t4_err", bus.err, 1);
    chk("t4_result", bus.result, 0);
    repeat (3) @(negedge clk);
    chk("t4_err_held", bus.err, 1);
    chk("t4_result_held", bus.result, 0);

    // Next start with odd n clears err
    run_mul(8'd5, 8'd7, 8'd13, lat, bsy, e0);
    chk("t5_err_cleared_at_start", e0, 0);
    chk("t5_err", bus.err, 0);
    chk("t5_result", bus.result, 1);
    @(negedge clk);

    // start held high throughout, inputs scrambled mid-run
    bus.start  = 1'b1;
    bus.a      = 8'd5;
    bus.b      = 8'd7;
    bus.n      = 8'd13;
    dones      = 0;
    first_done = -1;
    res_snap   = '0;
    @(posedge clk);
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (j == 2) begin
        bus.a = 8'd12;
        bus.b = 8'd12;
        bus.n = 8'd12;
      end
      if (bus.done) begin
        dones++;
        if (first_done < 0) begin
          first_done = j;
          res_snap   = bus.result;
        end
      end
      if (j == 10) bus.start = 1'b0;
    end
    chk("t6_done_count", dones, 1);
    chk("t6_done_latency", first_done, 10);
    chk("t6_result", res_snap, 1);
    chk("t6_err", bus.err, 0);

    // Reset in the 4th ITER cycle
    bus.start = 1'b1;
    bus.a     = 8'd12;
    bus.b     = 8'd12;
    bus.n     = 8'd13;
    @(posedge clk);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", bus.busy, 0);
    chk("t7_rst_done", bus.done, 0);
    chk("t7_rst_err", bus.err, 0);
    chk("t7_rst_result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("t7_no_done", dones, 0);
    run_mul(8'd5, 8'd7, 8'd13, lat, bsy, e0);
    chk("t7_latency", lat, 10);
    chk("t7_result", bus.result, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
